// File: rtl/random_arbiter.sv
// random_arbiter: round-robin grant of a captured random byte to one of four requesters, with a HOLD-cycle gap between grants.
module random_arbiter #(
  parameter int HOLD = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic [7:0] rand_in,
  output logic [3:0] grant,
  output logic [7:0] rand_out,
  output logic [1:0] dir_out,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, GAP = 2'd2} state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d, grant_q, grant_d;
  logic [7:0] rand_q, rand_d;
  logic [1:0] dir_q, dir_d, last_q, last_d, win;
  logic       busy_q, busy_d, take;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      rand_q  <= 8'hAA;
      dir_q   <= 2'b00;
      last_q  <= 2'd3;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      rand_q  <= rand_d;
      dir_q   <= dir_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end
  // Scan offsets from farthest to nearest so the nearest set bit after last_q wins.
  always_comb begin
    win = last_q;
    for (int k = 4; k >= 1; k--)
      if (req[last_q + 2'(k)]) win = last_q + 2'(k);
  end
  always_comb begin
    take    = state_q == IDLE && |req;
    state_d = state_q == IDLE ? (take ? GRANT : IDLE) :
              state_q == GRANT ? GAP :
              (state_q == GAP && cnt_q != 4'd0) ? GAP : IDLE;
  end
  always_comb begin
    grant_d = take ? 4'b0001 << win : 4'b0000;
    rand_d  = take ? rand_in : rand_q;
    dir_d   = take ? rand_in[7:6] ^ rand_in[1:0] : dir_q;
    last_d  = take ? win : last_q;
    cnt_d   = state_q == GRANT ? 4'(HOLD - 1) :
              (state_q == GAP && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    busy_d  = state_d != IDLE;
  end
  assign grant    = grant_q;
  assign rand_out = rand_q;
  assign dir_out  = dir_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_random_arbiter.sv
// tb_random_arbiter: directed stimulus pushes expected grants to a queue; a negedge monitor pops and compares each grant.
module tb_random_arbiter;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] rand_in = '0;
  logic [3:0] grant;
  logic [7:0] rand_out;
  logic [1:0] dir_out;
  logic       busy;
  int         cyc = 0, errors = 0, checks = 0;
  typedef struct {logic [3:0] g; logic [7:0] r; int c;} exp_t;
  exp_t q[$];
  random_arbiter #(.HOLD(2)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .rand_in(rand_in),
    .grant(grant), .rand_out(rand_out), .dir_out(dir_out), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [3:0] g, input logic [7:0] r, input int c);
    exp_t e;
    e.g = g;
    e.r = r;
    e.c = c;
    q.push_back(e);
  endtask
  task automatic settle();
    repeat (5) tick();
  endtask
  function automatic logic [1:0] dir_of(input logic [7:0] r);
    return r[7:6] ^ r[1:0];
  endfunction
  always @(negedge clk) begin
    if (grant != 4'b0000) begin
      exp_t e;
      chk("grant_onehot", 32'($countones(grant)), 32'd1);
      if (q.size() == 0) begin
        chk("unexpected_grant", 32'(grant), 32'd0);
      end else begin
        e = q.pop_front();
        chk("grant", 32'(grant), 32'(e.g));
        chk("grant_cycle", 32'(cyc), 32'(e.c));
        chk("rand_out", 32'(rand_out), 32'(e.r));
        chk("dir_out", 32'(dir_out), 32'(dir_of(e.r)));
        chk("busy_in_grant", 32'(busy), 32'd1);
      end
    end
  end
  initial begin
    logic [3:0] tbl [4];
    tbl = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rand", 32'(rand_out), 32'hAA);
    chk("rst_dir", 32'(dir_out), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_rand", 32'(rand_out), 32'hAA);
    end
    tick();
    req = 4'b1111;
    rand_in = 8'h21;
    push(4'b0001, rand_in, cyc + 1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      rand_in = rand_in + 8'h1D;
      if (i % 4 == 0) push(tbl[i / 4 - 1], rand_in, cyc + 1);
    end
    tick();
    req = 4'b0000;
    settle();
    req = 4'b0100;
    rand_in = 8'h5C;
    push(4'b0100, 8'h5C, cyc + 1);
    tick();
    req = 4'b0000;
    settle();
    req = 4'b0010;
    rand_in = 8'h11;
    push(4'b0010, 8'h11, cyc + 1);
    tick();
    req = 4'b0000;
    settle();
    req = 4'b0011;
    rand_in = 8'h3E;
    push(4'b0001, 8'h3E, cyc + 1);
    tick();
    rand_in = 8'h47;
    repeat (3) tick();
    push(4'b0010, 8'h47, cyc + 1);
    tick();
    req = 4'b0000;
    settle();
    req = 4'b0100;
    rand_in = 8'h99;
    push(4'b0100, 8'h99, cyc + 1);
    tick();
    req = 4'b0000;
    tick();
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    chk("gap_rst_busy", 32'(busy), 32'd0);
    chk("gap_rst_grant", 32'(grant), 32'd0);
    chk("gap_rst_rand", 32'(rand_out), 32'hAA);
    chk("gap_rst_dir", 32'(dir_out), 32'd0);
    reset_n = 1'b1;
    req = 4'b1010;
    rand_in = 8'h64;
    push(4'b0010, 8'h64, cyc + 1);
    tick();
    req = 4'b0000;
    settle();
    req = 4'b0001;
    rand_in = 8'h0F;
    push(4'b0001, 8'h0F, cyc + 1);
    tick();
    req = 4'b0000;
    tick();
    req = 4'b1000;
    tick();
    req = 4'b0000;
    repeat (6) tick();
    @(negedge clk);
    chk("pulse_busy", 32'(busy), 32'd0);
    chk("pulse_rand_hold", 32'(rand_out), 32'h0F);
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    chk("missing_grants", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
